data_memory: RTL and testbench
==============================

Name: data_memory

Overview:
- Word-organised data RAM for the RV32I single-core CPU.
- Serves load/store accesses from the datapath.
- Reads are combinational; writes are synchronous, with per-byte lane enables.
- The store-alignment logic upstream presents WD already shifted into the correct byte lanes.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words stored (power of two, ≥4).
- ADDR_LSB, 2, number of low byte-address bits ignored for word selection.

Ports:
- clk  input  1  rising-edge clock for writes.
- rst  input  1  asynchronous active-low reset; clears the whole array.
- WriteEnable  input  4  byte-lane write enables; bit j controls byte j = bits [8j+7:8j].
- address  input  32  byte address from the ALU.
- WD  input  32  write data, lane-aligned.
- RD  output  32  read data, full word at the addressed location.

Behaviour:
- Word index = address[ADDR_LSB+log2(DEPTH_WORDS)-1 : ADDR_LSB].
  - address[1:0] is ignored (no misalignment trap; alignment is handled upstream).
  - Upper address bits above the index are ignored, so addresses alias modulo DEPTH_WORDS*4 bytes.
- Reset:
  - While rst=0, all words are asynchronously forced to 32'h0, so RD = 32'h0.
  - Writes are blocked while rst=0.
  - Reset takes effect immediately, mid-cycle, regardless of the clock.
- Write:
  - On rising clk with rst=1, for each j where WriteEnable[j]=1, mem[idx] byte j <= WD byte j.
  - Bytes with WriteEnable[j]=0 are unchanged.
  - WriteEnable=4'b0000 is a pure read.
  - 4'b1111 is a word store (sw), 4'b0011/4'b1100 are halfword stores (sh), one-hot values are byte stores (sb).
  - Any other enable pattern still writes exactly the enabled lanes.
- Read:
  - RD = mem[idx], combinational, zero latency from address change.
  - Always a full word; sign/zero extension and byte selection for lb/lh/lbu/lhu are done downstream.
- Read-during-write, same index: before the edge RD shows old data; after the edge RD shows merged new data in the same cycle it is stored, with no extra delay.
- Write and read to different indices are independent.
- Reset released (rst 0→1) coincident with a clock edge: that edge performs no write.
- No X propagation after reset: every word is defined.

Test Plan:
- Reset readback:
  - Assert rst=0 for one cycle, release, WriteEnable=0.
  - Read address=0,1,2,3,4 (10-time-unit steps) -> RD=32'h00000000 each.
  - address 0–3 all select word 0.
- Word store/load:
  - WriteEnable=4'b1111, address=32'h8, WD=32'hDEADBEEF, one edge.
  - Then WriteEnable=0 -> RD=32'hDEADBEEF at address 8, 9, 10 and 11.
  - RD=0 at address 4 and 12.
- Byte-lane merge:
  - After the DEADBEEF write, WriteEnable=4'b0100, WD=32'h00AA0000 at address 8 -> RD=32'hDEAABEEF.
  - Then WriteEnable=4'b0011, WD=32'h00001234 -> RD=32'hDEAA1234.
- Read-during-write:
  - Hold address=32'h10, WD=32'h55555555, WriteEnable=4'b1111.
  - RD=0 before the edge, 32'h55555555 immediately after.
- Aliasing: write 32'hCAFEF00D at address 0 with DEPTH_WORDS=256, then read address 32'h400 -> RD=32'hCAFEF00D.
- Async reset mid-operation:
  - After nonzero writes, drop rst between clock edges -> RD=0 immediately.
  - A clock edge with WriteEnable=4'b1111 while rst=0 leaves the word at 0 after release.

Source files
------------

// File: rtl/data_memory.sv
// data_memory: word-organised data RAM for the RV32I datapath, with byte-lane writes and an async clear.
// Latency: read is combinational, write lands on the clk rise; no backpressure (every access is accepted).
module data_memory #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_LSB    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  WriteEnable,
    input  logic [31:0] address,
    input  logic [31:0] WD,
    output logic [31:0] RD
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [IDX_W-1:0] idx;
    logic [31:0]      mem [DEPTH_WORDS];
    logic             unused_addr;

    // Byte offset and bits above the index are dropped, so addresses alias modulo the array size.
    assign idx         = address[ADDR_LSB+IDX_W-1:ADDR_LSB];
    assign unused_addr = ^{address[31:ADDR_LSB+IDX_W], address[ADDR_LSB-1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= 32'h0;
            end
        end else begin
            for (int j = 0; j < 4; j++) begin
                if (WriteEnable[j]) begin
                    mem[idx][8*j +: 8] <= WD[8*j +: 8];
                end
            end
        end
    end

    assign RD = mem[idx];

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: stimulus pushes expected read words, a monitor pops and compares RD.
`timescale 1ns/1ps
module tb_data_memory;

    logic        clk;
    logic        rst;
    logic [3:0]  WriteEnable;
    logic [31:0] address;
    logic [31:0] WD;
    logic [31:0] RD;

    int checks;
    int errors;
    int push_cnt;
    int pop_cnt;

    logic [31:0] exp_q  [$];
    string       name_q [$];

    data_memory #(.DEPTH_WORDS(256), .ADDR_LSB(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .WriteEnable(WriteEnable),
        .address    (address),
        .WD         (WD),
        .RD         (RD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: samples RD one time unit after each expectation is queued.
    initial begin
        logic [31:0] e;
        string       n;
        forever begin
            wait (push_cnt != pop_cnt);
            #1;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (RD !== e) begin
                errors++;
                $display("FAIL %s: RD=%h expected=%h (addr=%h t=%0t)", n, RD, e, address, $time);
            end
            pop_cnt++;
        end
    end

    task automatic expect_rd(input string n, input logic [31:0] e);
        exp_q.push_back(e);
        name_q.push_back(n);
        push_cnt++;
        for (int k = 0; k < 20 && pop_cnt != push_cnt; k++) #1;
        if (pop_cnt != push_cnt) begin
            errors++;
            $display("FAIL %s: monitor timeout, popped=%0d required=%0d", n, pop_cnt, push_cnt);
        end
    endtask

    task automatic write_word(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
        @(negedge clk);
        address     = a;
        WriteEnable = we;
        WD          = d;
        @(posedge clk);
        @(negedge clk);
        WriteEnable = 4'b0000;
    endtask

    initial begin
        checks = 0; errors = 0; push_cnt = 0; pop_cnt = 0;
        WriteEnable = 4'b0000;
        address     = 32'h0;
        WD          = 32'h0;
        rst         = 1'b1;
        #1 rst = 1'b0;
        expect_rd("rst_active", 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Reset readback; addresses 0..3 all land on word 0.
        for (int a = 0; a <= 4; a++) begin
            address = a;
            expect_rd($sformatf("rst_read_%0d", a), 32'h0);
            #8;
        end

        // Word store, then readback across the byte offsets and neighbours.
        write_word(32'h8, 4'b1111, 32'hDEADBEEF);
        for (int a = 8; a <= 11; a++) begin
            address = a;
            expect_rd($sformatf("sw_read_%0d", a), 32'hDEADBEEF);
        end
        address = 32'h4;
        expect_rd("neighbour_4", 32'h0);
        address = 32'hC;
        expect_rd("neighbour_12", 32'h0);

        // Byte and halfword merges into the existing word.
        write_word(32'h8, 4'b0100, 32'h00AA0000);
        expect_rd("sb_lane2", 32'hDEAABEEF);
        write_word(32'h8, 4'b0011, 32'h00001234);
        expect_rd("sh_low", 32'hDEAA1234);
        write_word(32'h8, 4'b1001, 32'h77FFFF66);
        expect_rd("sparse_lanes", 32'h77AA1266);

        // Read-during-write at the same index.
        @(negedge clk);
        address     = 32'h10;
        WD          = 32'h55555555;
        WriteEnable = 4'b1111;
        expect_rd("rdw_before", 32'h0);
        @(posedge clk);
        expect_rd("rdw_after", 32'h55555555);
        @(negedge clk);
        WriteEnable = 4'b0000;

        // Aliasing modulo 1 KiB.
        write_word(32'h0, 4'b1111, 32'hCAFEF00D);
        address = 32'h400;
        expect_rd("alias_400", 32'hCAFEF00D);
        address = 32'h0;
        expect_rd("alias_0", 32'hCAFEF00D);

        // Async reset between edges, then a blocked write while held.
        write_word(32'h20, 4'b1111, 32'h12345678);
        address = 32'h20;
        expect_rd("pre_reset", 32'h12345678);
        @(negedge clk);
        #2 rst = 1'b0;
        expect_rd("async_clear", 32'h0);
        address = 32'h8;
        expect_rd("async_clear_8", 32'h0);
        address     = 32'h20;
        WD          = 32'hFFFFFFFF;
        WriteEnable = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        WriteEnable = 4'b0000;
        rst         = 1'b1;
        expect_rd("blocked_write", 32'h0);
        address = 32'h400;
        expect_rd("alias_cleared", 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

endmodule
